// File: rtl/dispatch_ctrl_if.sv
// Bundle between dispatch_ctrl and its neighbours: fetch push, decode loop-back,
// issue handshake and ROB/LSQ retirement/flush.
//   master: the dispatch_ctrl side (drives fetch_ready, dec_instr, disp_*, illegal,
//           rob_count, lsq_count)
//   slave : fetch/decode/issue/ROB/LSQ side (drives everything else)
interface dispatch_ctrl_if #(
  parameter int unsigned ROB_TAG_W = 4,
  parameter int unsigned LSQ_DEPTH = 8
);
  localparam int unsigned LsqCntW = $clog2(LSQ_DEPTH + 1);

  logic                 fetch_valid;
  logic                 fetch_ready;
  logic [31:0]          fetch_instr;
  logic [31:0]          dec_instr;
  logic                 dec_is_load;
  logic                 dec_is_store;
  logic                 dec_valid;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [31:0]          disp_instr;
  logic [ROB_TAG_W-1:0] disp_rob_tag;
  logic                 disp_is_mem;
  logic                 rob_commit;
  logic                 lsq_release;
  logic                 flush;
  logic                 illegal;
  logic [ROB_TAG_W:0]   rob_count;
  logic [LsqCntW-1:0]   lsq_count;

  modport master (
    input  fetch_valid, fetch_instr, dec_is_load, dec_is_store, dec_valid,
           disp_ready, rob_commit, lsq_release, flush,
    output fetch_ready, dec_instr, disp_valid, disp_instr, disp_rob_tag,
           disp_is_mem, illegal, rob_count, lsq_count
  );

  modport slave (
    output fetch_valid, fetch_instr, dec_is_load, dec_is_store, dec_valid,
           disp_ready, rob_commit, lsq_release, flush,
    input  fetch_ready, dec_instr, disp_valid, disp_instr, disp_rob_tag,
           disp_is_mem, illegal, rob_count, lsq_count
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// In-order dispatch sequencer. Buffers fetched words in a small FIFO, presents
// the head to an external combinational decoder, then dispatches one word per
// cycle on a valid/ready handshake, allocating a ROB tag (and an LSQ slot for
// memory ops). Stalls when ROB or LSQ is full, drops illegal heads, flushes.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dispatch_ctrl_if master modport (fetch, decode, issue, ROB/LSQ, flush)
module dispatch_ctrl #(
  parameter int unsigned IQ_DEPTH  = 4,
  parameter int unsigned ROB_TAG_W = 4,
  parameter int unsigned LSQ_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dispatch_ctrl_if.master bus
);
  localparam int unsigned PtrW    = $clog2(IQ_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned RobCntW = ROB_TAG_W + 1;
  localparam int unsigned LsqCntW = $clog2(LSQ_DEPTH + 1);

  localparam logic [CntW-1:0]    IqCap  = CntW'(IQ_DEPTH);
  localparam logic [RobCntW-1:0] RobCap = {1'b1, {ROB_TAG_W{1'b0}}};
  localparam logic [LsqCntW-1:0] LsqCap = LsqCntW'(LSQ_DEPTH);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  state_e               state_q, state_d;
  logic [31:0]          mem_q [IQ_DEPTH];
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      iq_cnt_q, iq_cnt_d;
  logic [ROB_TAG_W-1:0] tag_q, tag_d;
  logic [RobCntW-1:0]   rob_cnt_q, rob_cnt_d;
  logic [LsqCntW-1:0]   lsq_cnt_q, lsq_cnt_d;
  logic                 illegal_q, illegal_d;

  logic head_valid;
  logic is_mem;
  logic can_go;
  logic disp_valid;
  logic fetch_ready;
  logic fire;
  logic drop;
  logic push;
  logic pop;
  logic rob_dec;
  logic lsq_inc;
  logic lsq_dec;

  assign head_valid = (iq_cnt_q != '0);
  assign is_mem     = bus.dec_is_load | bus.dec_is_store;
  assign can_go     = head_valid & bus.dec_valid & (rob_cnt_q != RobCap) &
                      (~is_mem | (lsq_cnt_q != LsqCap));
  assign disp_valid = can_go & (state_q == StRun);
  // Reset is folded in so fetch sees no ready while the block is held in reset.
  assign fetch_ready = rst_n & (iq_cnt_q != IqCap) & (state_q != StFlush);

  // Flush dominates: nothing fires, drops or enters the buffer on a flush edge.
  assign fire    = disp_valid & bus.disp_ready & ~bus.flush;
  assign drop    = head_valid & ~bus.dec_valid & (state_q == StRun) & ~bus.flush;
  assign push    = bus.fetch_valid & fetch_ready & ~bus.flush;
  assign pop     = fire | drop;
  assign rob_dec = bus.rob_commit & (rob_cnt_q != '0);
  assign lsq_inc = fire & is_mem;
  assign lsq_dec = bus.lsq_release & (lsq_cnt_q != '0);

  assign bus.fetch_ready  = fetch_ready;
  assign bus.dec_instr    = head_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign bus.disp_instr   = bus.dec_instr;
  assign bus.disp_valid   = disp_valid;
  assign bus.disp_rob_tag = tag_q;
  assign bus.disp_is_mem  = is_mem;
  assign bus.illegal      = illegal_q;
  assign bus.rob_count    = rob_cnt_q;
  assign bus.lsq_count    = lsq_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (head_valid && bus.dec_valid && !can_go) state_d = StStall;
      StStall: if (can_go) state_d = StRun;
      StFlush: state_d = StRun;
      default: state_d = StRun;
    endcase
    if (bus.flush) state_d = StFlush;
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    iq_cnt_d  = iq_cnt_q;
    tag_d     = tag_q;
    rob_cnt_d = rob_cnt_q;
    lsq_cnt_d = lsq_cnt_q;
    illegal_d = drop;
    if (bus.flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      iq_cnt_d  = '0;
      tag_d     = '0;
      rob_cnt_d = '0;
      lsq_cnt_d = '0;
      illegal_d = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      iq_cnt_d = iq_cnt_q + CntW'(push) - CntW'(pop);
      if (fire) tag_d = tag_q + ROB_TAG_W'(1);
      // Simultaneous allocate and retire leaves the count unchanged.
      rob_cnt_d = rob_cnt_q + RobCntW'(fire) - RobCntW'(rob_dec);
      lsq_cnt_d = lsq_cnt_q + LsqCntW'(lsq_inc) - LsqCntW'(lsq_dec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      iq_cnt_q  <= '0;
      tag_q     <= '0;
      rob_cnt_q <= '0;
      lsq_cnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      iq_cnt_q  <= iq_cnt_d;
      tag_q     <= tag_d;
      rob_cnt_q <= rob_cnt_d;
      lsq_cnt_q <= lsq_cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Payload storage needs no reset: dec_instr is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.fetch_instr;
  end
endmodule
